// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared phase encoding and default sizing for the breathing-LED driver
package led_pkg;

    typedef enum logic [1:0] {
        LOW_HOLD  = 2'd0,
        RISE      = 2'd1,
        HIGH_HOLD = 2'd2,
        FALL      = 2'd3
    } phase_t;

    localparam int DEFAULT_DUTY_W = 8;
    localparam int DEFAULT_HOLD   = 32;

endpackage

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - free-running PWM carrier with a wrap-aligned duty shadow and registered compare
module led_pwm
    import led_pkg::*;
#(
    parameter int DUTY_W = DEFAULT_DUTY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty,
    output logic              LED
);

    logic [DUTY_W-1:0] pwm_cnt;
    logic [DUTY_W-1:0] duty_sh;

    // duty_sh only moves on the wrap edge so every carrier period sees a single duty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            duty_sh <= '0;
            LED     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
            if (pwm_cnt == '1) begin
                duty_sh <= duty;
            end
            LED <= enable & (pwm_cnt < duty_sh);
        end
    end

endmodule

// File: rtl/led_breathe.sv
// rtl/led_breathe.sv - tick-stepped four-phase duty sequencer driving the PWM LED output
module led_breathe
    import led_pkg::*;
#(
    parameter int DUTY_W = DEFAULT_DUTY_W,
    parameter int HOLD   = DEFAULT_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_in,
    input  logic              enable,
    output logic              LED,
    output logic [DUTY_W-1:0] duty,
    output logic [1:0]        phase
);

    localparam int                HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD - 1);
    localparam logic [DUTY_W-1:0] MAX       = '1;
    localparam logic [DUTY_W-1:0] NEAR_MAX  = MAX - DUTY_W'(1);
    localparam logic [DUTY_W-1:0] ONE       = DUTY_W'(1);

    phase_t        state;
    logic [HW-1:0] hold_cnt;
    logic          tick_d;
    logic          step;

    assign step  = tick_in & ~tick_d & enable;
    assign phase = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOW_HOLD;
            duty     <= '0;
            hold_cnt <= '0;
            tick_d   <= 1'b0;
        end else begin
            tick_d <= tick_in;
            if (!enable) begin
                state    <= LOW_HOLD;
                duty     <= '0;
                hold_cnt <= '0;
            end else if (step) begin
                case (state)
                    LOW_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= RISE;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    RISE: begin
                        duty <= duty + ONE;
                        if (duty == NEAR_MAX) begin
                            state    <= HIGH_HOLD;
                            hold_cnt <= '0;
                        end
                    end
                    HIGH_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= FALL;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    FALL: begin
                        duty <= duty - ONE;
                        if (duty == ONE) begin
                            state    <= LOW_HOLD;
                            hold_cnt <= '0;
                        end
                    end
                    default: state <= LOW_HOLD;
                endcase
            end
        end
    end

    led_pwm #(
        .DUTY_W(DUTY_W)
    ) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .duty  (duty),
        .LED   (LED)
    );

endmodule

// File: tb/tb_led_breathe.sv
// tb/tb_led_breathe.sv - randomized self-checking bench for led_breathe against a step-count model
module tb_led_breathe;

    localparam int DW   = 4;
    localparam int HOLD = 2;
    localparam int MAX  = 15;
    localparam int PER  = 2 * MAX + 2 * HOLD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick_in = 1'b0;
    logic          enable = 1'b1;
    logic          LED;
    logic [DW-1:0] duty;
    logic [1:0]    phase;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int ecount = 0;

    led_breathe #(.DUTY_W(DW), .HOLD(HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_in(tick_in),
        .enable (enable),
        .LED    (LED),
        .duty   (duty),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    // edges since reset release; the carrier counter equals this modulo 2^DW
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    // expected {phase, duty} after a given number of enabled steps from a restart
    function automatic logic [5:0] model(input int steps);
        int m;
        m = steps % PER;
        if (m < HOLD)                 return {2'd0, 4'd0};
        else if (m < HOLD + MAX)      return {2'd1, 4'(m - HOLD)};
        else if (m < 2 * HOLD + MAX)  return {2'd2, 4'(MAX)};
        else                          return {2'd3, 4'(MAX - (m - 2 * HOLD - MAX))};
    endfunction

    task automatic step_once();
        repeat ($urandom_range(1, 3)) @(negedge clk);
        tick_in = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        tick_in = 1'b0;
        @(negedge clk);
        n++;
    endtask

    task automatic count_period(output int cnt);
        int g;
        cnt = 0;
        g = 0;
        @(negedge clk);
        while ((ecount % 16) != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (LED === 1'b1) cnt++;
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({LED, phase, duty} !== 7'd0) begin
            failures++;
            $display("FAIL reset_state: led=%0b phase=%0d duty=%0d required 0/0/0", LED, phase, duty);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if ({LED, phase, duty} !== 7'd0) begin
            failures++;
            $display("FAIL reset_idle: led=%0b phase=%0d duty=%0d required 0/0/0", LED, phase, duty);
        end
    endtask

    task automatic test_single_step();
        int cnt;
        repeat (2) step_once();
        checks++;
        if ({phase, duty} !== 6'b01_0000) begin
            failures++;
            $display("FAIL single_step_rise: phase=%0d duty=%0d required 1/0", phase, duty);
        end
        step_once();
        checks++;
        if ({phase, duty} !== 6'b01_0001) begin
            failures++;
            $display("FAIL single_step_duty1: phase=%0d duty=%0d required 1/1", phase, duty);
        end
        repeat (17) @(negedge clk);
        count_period(cnt);
        checks++;
        if (cnt !== 1) begin
            failures++;
            $display("FAIL single_step_led: high=%0d required 1", cnt);
        end
    endtask

    task automatic test_full_cycle();
        logic [5:0] e;
        int cnt;
        pulse_reset();
        for (int s = 0; s < PER; s++) begin
            step_once();
            e = model(n);
            checks++;
            if ({phase, duty} !== e) begin
                failures++;
                $display("FAIL full_cycle step %0d: phase=%0d duty=%0d required %0d/%0d",
                         n, phase, duty, e[5:4], e[3:0]);
            end
            if (n == HOLD + MAX) begin
                repeat (17) @(negedge clk);
                count_period(cnt);
                checks++;
                if (cnt !== MAX) begin
                    failures++;
                    $display("FAIL full_cycle_led_max: high=%0d required %0d", cnt, MAX);
                end
            end
        end
        checks++;
        if ({phase, duty} !== 6'd0) begin
            failures++;
            $display("FAIL full_cycle_end: phase=%0d duty=%0d required 0/0", phase, duty);
        end
    endtask

    task automatic test_held_tick();
        logic [5:0] e;
        while (n < HOLD + 3) step_once();
        @(negedge clk);
        tick_in = 1'b1;
        repeat (100) @(negedge clk);
        tick_in = 1'b0;
        @(negedge clk);
        n++;
        e = model(n);
        checks++;
        if ({phase, duty} !== e) begin
            failures++;
            $display("FAIL held_tick: phase=%0d duty=%0d required %0d/%0d", phase, duty, e[5:4], e[3:0]);
        end
    endtask

    task automatic test_shadow();
        logic [5:0] e_old;
        logic [5:0] e_new;
        int cnt_old;
        int cnt_new;
        int g;
        e_old = model(n);
        e_new = model(n + 1);
        repeat (20) @(negedge clk);
        g = 0;
        while ((ecount % 16) != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        cnt_old = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) tick_in = 1'b1;
            if (i == 6) tick_in = 1'b0;
            @(posedge clk);
            #1;
            if (LED === 1'b1) cnt_old++;
            @(negedge clk);
        end
        n++;
        count_period(cnt_new);
        checks++;
        if (cnt_old !== int'(e_old[3:0])) begin
            failures++;
            $display("FAIL shadow_old_period: high=%0d required %0d", cnt_old, e_old[3:0]);
        end
        checks++;
        if (cnt_new !== int'(e_new[3:0])) begin
            failures++;
            $display("FAIL shadow_new_period: high=%0d required %0d", cnt_new, e_new[3:0]);
        end
    endtask

    task automatic test_enable_drop();
        logic [5:0] e;
        int highs;
        int guard;
        guard = 0;
        while (model(n) !== 6'b01_1001 && guard < 2 * PER) begin
            step_once();
            guard++;
        end
        checks++;
        if ({phase, duty} !== 6'b01_1001) begin
            failures++;
            $display("FAIL enable_drop_setup: phase=%0d duty=%0d required 1/9", phase, duty);
        end
        repeat (20) @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({LED, phase, duty} !== 7'd0) begin
            failures++;
            $display("FAIL enable_drop_clear: led=%0b phase=%0d duty=%0d required 0/0/0", LED, phase, duty);
        end
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            tick_in = i[1];
            if (LED === 1'b1) highs++;
        end
        tick_in = 1'b0;
        @(negedge clk);
        checks++;
        if (highs !== 0 || {phase, duty} !== 6'd0) begin
            failures++;
            $display("FAIL enable_low_hold: led_highs=%0d phase=%0d duty=%0d required 0/0/0", highs, phase, duty);
        end
        enable = 1'b1;
        n = 0;
        for (int s = 0; s < HOLD + 1; s++) begin
            step_once();
            e = model(n);
            checks++;
            if ({phase, duty} !== e) begin
                failures++;
                $display("FAIL reenable step %0d: phase=%0d duty=%0d required %0d/%0d",
                         n, phase, duty, e[5:4], e[3:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] e;
        int cnt;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                enable = 1'b0;
                repeat ($urandom_range(1, 10)) @(negedge clk);
                enable = 1'b1;
                n = 0;
            end
            repeat ($urandom_range(1, 6)) step_once();
            e = model(n);
            checks++;
            if ({phase, duty} !== e) begin
                failures++;
                $display("FAIL random it %0d n %0d: phase=%0d duty=%0d required %0d/%0d",
                         it, n, phase, duty, e[5:4], e[3:0]);
            end
            if ($urandom_range(0, 4) == 0) begin
                repeat (17) @(negedge clk);
                count_period(cnt);
                checks++;
                if (cnt !== int'(e[3:0])) begin
                    failures++;
                    $display("FAIL random_led it %0d: high=%0d required %0d", it, cnt, e[3:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        while (model(n) >> 4 != 2'd1 || model(n) == 6'b01_0000) step_once();
        @(negedge clk);
        tick_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({LED, phase, duty} !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid_async: led=%0b phase=%0d duty=%0d required 0/0/0", LED, phase, duty);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tick_in = ~tick_in;
        end
        tick_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (20) @(negedge clk);
        checks++;
        if ({LED, phase, duty} !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid_idle: led=%0b phase=%0d duty=%0d required 0/0/0", LED, phase, duty);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_full_cycle();
        test_held_tick();
        test_shadow();
        test_enable_drop();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_breathe.md
# led_breathe

Breathing-LED driver that consumes the slow square-wave tick produced by the board's free-running blink divider and turns it into a PWM LED drive. Each rising edge of the tick steps the duty cycle through a four-phase sequence: ramp up, hold bright, ramp down, hold dark. It replaces a raw divider bit on the LED pin wherever a soft fade is wanted. The PWM carrier runs from the same clock and updates glitch-free.

## Interface
- DUTY_W, 8: width of the duty and PWM counters. MAX = 2^DUTY_W − 1.
- HOLD, 32: number of tick steps spent in each hold phase. Must be ≥ 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick_in  in  1  slow square wave, synchronous to clk, for example a divider MSB. Only rising edges are used.
- enable  in  1  when 0, LED is forced low and the sequence is parked at dark.
- LED  out  1  registered PWM output.
- duty  out  DUTY_W  current target duty.
- phase  out  2  FSM state: 0 LOW_HOLD, 1 RISE, 2 HIGH_HOLD, 3 FALL.

## Operation
- Edge detect: tick_d <= tick_in; step = tick_in & ~tick_d & enable.
- FSM, evaluated on step only. With no step, all FSM state holds.
  - LOW_HOLD: if hold_cnt == HOLD−1, go to RISE and set hold_cnt <= 0. Otherwise hold_cnt++.
  - RISE: duty++. If the new duty == MAX, go to HIGH_HOLD and set hold_cnt <= 0.
  - HIGH_HOLD: same counting rule as LOW_HOLD, exiting to FALL.
  - FALL: duty−−. If the new duty == 0, go to LOW_HOLD and set hold_cnt <= 0.
- duty never wraps. It saturates by construction: range 0..MAX.
- enable == 0 applies a synchronous clear every cycle: phase = LOW_HOLD, duty = 0, hold_cnt = 0. tick_d keeps tracking tick_in. When enable returns high, the sequence restarts from LOW_HOLD, hold_cnt 0.
- PWM:
  - pwm_cnt is a free-running DUTY_W-bit counter that wraps MAX→0.
  - When pwm_cnt == MAX, duty_sh <= duty.
  - Every cycle, LED <= enable & (pwm_cnt < duty_sh).
  - Result: duty 0 gives constant 0. Duty MAX gives high for MAX of every 2^DUTY_W cycles.
- Full breathe period = (2·MAX + 2·HOLD) steps.

## Timing
- Reset values: LED 0, duty 0, phase 0, hold_cnt 0, pwm_cnt 0, duty_sh 0, tick_d 0.
- Step latency:
  - tick_in is first sampled high at edge k with tick_d low. duty and phase update at edge k, visible in the following cycle.
  - A tick_in already high when rst_n releases counts as one step at the first edge.
- duty → LED latency: the new duty is adopted at the next pwm_cnt == MAX edge. LED reflects it starting one cycle after the wrap, when pwm_cnt == 0 is compared. At most 2^DUTY_W + 1 cycles.
- duty_sh changes only at wrap. No PWM period ever sees two different duties.
- If tick_in is held high, only one step is taken. Each extra step requires a 0→1 transition.
- enable falling: LED is 0 from the next edge. duty and phase clear at the same edge.
- Async reset mid-ramp: all state is cleared immediately, with no wait for clk.

## Structure
- Package led_pkg holds:
  - the phase_t enum: LOW_HOLD = 2'd0, RISE = 2'd1, HIGH_HOLD = 2'd2, FALL = 2'd3
  - the default DUTY_W and HOLD constants.
- One sub-module, led_pwm: contains pwm_cnt, the duty_sh shadow and the registered compare. Ports: clk, rst_n, enable, duty, LED.
- Top level contains the edge detect, FSM, duty counter and hold_cnt.
- hold_cnt width: $clog2(HOLD) bits, minimum 1.

## Test plan
- Reset: assert rst_n = 0 mid-simulation with tick_in toggling → LED, duty and phase all 0 immediately. After release, with tick_in held at 0, they stay 0.
- Single step, DUTY_W = 4, HOLD = 2: two tick rising edges → phase 1 with duty 0. Third edge → duty 1. Next pwm wrap → LED high exactly 1 of 16 cycles.
- Full cycle, DUTY_W = 4, HOLD = 2:
  - 2 + 15 steps → duty 15, phase 2.
  - 2 more steps → phase 3.
  - 15 more steps → duty 0, phase 0.
  - 34 steps total; duty never exceeds 15 or wraps below 0.
- Held tick: tick_in held high for 100 clk → duty/hold_cnt advances by exactly one step.
- Shadow: change duty mid-PWM-period (a step at pwm_cnt = 5) → the LED high count in that period still equals the old duty. The next period equals the new duty.
- Enable drop in RISE at duty 9:
  - enable = 0 → LED 0 and duty 0 next cycle, phase 0.
  - Re-enable → HOLD steps then RISE from 0.
